// File: rtl/cpu_core_mc.sv
// cpu_core_mc: multi-cycle core for the 16-bit ISA (FETCH -> EXEC -> [MEM] -> WB) with valid/ready fetch
// and a stallable data port. Define CPU_BRANCH_EN to turn opcode 8 into BEQ; otherwise it is illegal.
module cpu_core_mc #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter bit                R0_ZERO  = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] pc,
   input  logic [15:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   output logic [DATA_W-1:0] alu_out,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              mem_ready,
   output logic              illegal_op
);
   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_WB} state_t;

   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SW  = 4'd6;
   localparam logic [3:0] OP_LI  = 4'd7;
`ifdef CPU_BRANCH_EN
   localparam logic [3:0] OP_BEQ  = 4'd8;
   localparam logic [3:0] OP_LAST = OP_BEQ;
   logic br_taken;
`else
   localparam logic [3:0] OP_LAST = OP_LI;
`endif

   state_t                  state;
   logic [15:0]             ir;
   logic [15:0][DATA_W-1:0] regs;
   logic [DATA_W-1:0]       ld_data, rs_val, rt_val, rd_val, imm_d, li_val, ea;
   logic [ADDR_W-1:0]       pc_next;
   logic [3:0]              op, rd, rs, rt;
   logic                    wr_en;

   assign op = ir[15:12];
   assign rd = ir[11:8];
   assign rs = ir[7:4];
   assign rt = ir[3:0];

   assign instr_ready = (state == S_FETCH);

   assign rs_val = (R0_ZERO && rs == 4'd0) ? '0 : regs[rs];
   assign rt_val = (R0_ZERO && rt == 4'd0) ? '0 : regs[rt];
   assign rd_val = (R0_ZERO && rd == 4'd0) ? '0 : regs[rd];
   assign imm_d  = {{(DATA_W-4){rt[3]}}, rt};
   assign li_val = {{(DATA_W-8){ir[7]}}, ir[7:0]};
   assign ea     = rs_val + imm_d;

   assign wr_en = (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LW, OP_LI}) &&
                  !(R0_ZERO && rd == 4'd0);

`ifdef CPU_BRANCH_EN
   assign pc_next = pc + ADDR_W'(1) +
                    ((op == OP_BEQ && br_taken) ? {{(ADDR_W-4){rt[3]}}, rt} : '0);
`else
   assign pc_next = pc + ADDR_W'(1);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_FETCH;
         pc         <= RESET_PC;
         ir         <= '0;
         regs       <= '0;
         ld_data    <= '0;
         alu_out    <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         illegal_op <= 1'b0;
`ifdef CPU_BRANCH_EN
         br_taken   <= 1'b0;
`endif
      end else begin
         illegal_op <= 1'b0;
         case (state)
            S_FETCH: if (instr_valid) begin
               ir         <= instr;
               // registered here so the pulse lines up with the EXEC cycle
               illegal_op <= (instr[15:12] > OP_LAST);
               state      <= S_EXEC;
            end
            S_EXEC: begin
               state <= S_WB;
               case (op)
                  OP_ADD: alu_out <= rs_val + rt_val;
                  OP_SUB: alu_out <= rs_val - rt_val;
                  OP_AND: alu_out <= rs_val & rt_val;
                  OP_OR:  alu_out <= rs_val | rt_val;
                  OP_LI:  alu_out <= li_val;
                  OP_LW: begin
                     alu_out  <= ea;
                     mem_addr <= ADDR_W'(ea);
                     mem_read <= 1'b1;
                     state    <= S_MEM;
                  end
                  OP_SW: begin
                     alu_out   <= ea;
                     mem_addr  <= ADDR_W'(ea);
                     mem_wdata <= rd_val;
                     mem_write <= 1'b1;
                     state     <= S_MEM;
                  end
`ifdef CPU_BRANCH_EN
                  OP_BEQ: br_taken <= (rd_val == rs_val);
`endif
                  default: ;
               endcase
            end
            S_MEM: if (mem_ready) begin
               if (mem_read) ld_data <= mem_data;
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               state     <= S_WB;
            end
            S_WB: begin
               if (wr_en) regs[rd] <= (op == OP_LW) ? ld_data : alu_out;
               pc    <= pc_next;
               state <= S_FETCH;
            end
            default: state <= S_FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_core_mc.sv
// Self-checking bench for cpu_core_mc: directed ISA scenarios plus randomized programs against an
// architectural model (register array, pc, expected latency and memory traffic per instruction).
module tb_cpu_core_mc;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] pc, instr, alu_out, mem_addr, mem_wdata, mem_data;
   logic        instr_valid, instr_ready, mem_read, mem_write, mem_ready, illegal_op;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cpu_core_mc #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000), .R0_ZERO(1'b1)) dut (
      .clk(clk), .reset(reset), .pc(pc), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .alu_out(alu_out), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_data(mem_data), .mem_ready(mem_ready),
      .illegal_op(illegal_op)
   );

   // architectural model
   logic [15:0] m_r [16];
   logic [15:0] m_pc, m_alu;
   int          exp_lat, exp_kind;   // kind: 0 none, 1 load, 2 store
   logic [15:0] exp_addr, exp_wdata;
   logic        exp_ill;

   // observations of the last executed instruction
   int          o_lat, o_rd, o_wr, o_ill_cnt;
   logic        o_ill_exec, o_to;
   logic [15:0] o_addr, o_wdata, o_pc, o_alu;

   function automatic logic [15:0] sx4(input logic [3:0] v);
      return {{12{v[3]}}, v};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_r[i] = 16'h0;
      m_pc  = 16'h0;
      m_alu = 16'h0;
   endtask

   task automatic model_step(input logic [15:0] ins, input int nwait, input logic [15:0] ld);
      logic [3:0]  op, rd, rs, rt;
      logic [15:0] a, b, d, res, next_pc;
      bit          wr;
      op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
      a = m_r[rs]; b = m_r[rt]; d = m_r[rd];
      wr = 0; res = 16'h0; exp_kind = 0; exp_ill = 1'b0;
      next_pc = m_pc + 16'd1;
      case (op)
         4'd0: ;
         4'd1: begin res = a + b; wr = 1; m_alu = res; end
         4'd2: begin res = a - b; wr = 1; m_alu = res; end
         4'd3: begin res = a & b; wr = 1; m_alu = res; end
         4'd4: begin res = a | b; wr = 1; m_alu = res; end
         4'd5: begin m_alu = a + sx4(rt); exp_addr = m_alu; exp_kind = 1; res = ld; wr = 1; end
         4'd6: begin m_alu = a + sx4(rt); exp_addr = m_alu; exp_wdata = d; exp_kind = 2; end
         4'd7: begin res = {{8{ins[7]}}, ins[7:0]}; wr = 1; m_alu = res; end
`ifdef CPU_BRANCH_EN
         4'd8: if (d == a) next_pc = m_pc + 16'd1 + sx4(rt);
`endif
         default: exp_ill = 1'b1;
      endcase
      if (wr && rd != 4'd0) m_r[rd] = res;
      m_pc = next_pc;
      exp_lat = (exp_kind != 0) ? 4 + nwait : 3;
   endtask

   // drives one instruction through the handshake and acts as the data memory
   task automatic exec_instr(input logic [15:0] ins, input int nwait, input logic [15:0] ld,
                             input int idle);
      int cyc, mc;
      model_step(ins, nwait, ld);
      cyc = 0;
      while (!instr_ready && cyc < 20) begin @(negedge clk); cyc++; end
      repeat (idle) @(negedge clk);
      instr = ins; instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0; instr = 16'($urandom);
      cyc = 1; mc = 0; o_rd = 0; o_wr = 0;
      o_addr = 16'h0; o_wdata = 16'h0;
      o_ill_exec = illegal_op; o_ill_cnt = illegal_op ? 1 : 0;
      while (!instr_ready && cyc < 40) begin
         if (mem_read || mem_write) begin
            if (mc == 0) begin o_addr = mem_addr; o_wdata = mem_wdata; end
            mc++;
            if (mem_read) o_rd++;
            if (mem_write) o_wr++;
            mem_ready = (mc == nwait + 1);
            mem_data  = mem_ready ? ld : 16'($urandom);
         end else begin
            mem_ready = 1'($urandom);
            mem_data  = 16'($urandom);
         end
         @(negedge clk); cyc++;
         if (illegal_op) o_ill_cnt++;
      end
      mem_ready = 1'b0;
      o_lat = cyc; o_to = !instr_ready;
      o_pc = pc; o_alu = alu_out;
   endtask

   task automatic test_reset();
      reset = 1'b1; instr_valid = 1'b1; instr = 16'h7F7F;
      repeat (2) @(negedge clk);
      reset = 1'b0; instr_valid = 1'b0;
      model_reset();
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", pc); end
      checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", instr_ready); end
      checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_mem got %b%b exp 00", mem_read, mem_write); end
      checks++; if (alu_out !== 16'h0000) begin errors++; $display("FAIL reset_alu got %h exp 0000", alu_out); end
      checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_ill got %b exp 0", illegal_op); end
   endtask

   task automatic test_alu();
      exec_instr(16'h7205, 0, 16'h0, 0);
      checks++; if (o_lat !== 3) begin errors++; $display("FAIL li_lat got %0d exp 3", o_lat); end
      exec_instr(16'h7307, 0, 16'h0, 1);
      checks++; if (o_lat !== 3) begin errors++; $display("FAIL li2_lat got %0d exp 3", o_lat); end
      exec_instr(16'h1123, 0, 16'h0, 0);
      checks++; if (o_alu !== 16'h000C) begin errors++; $display("FAIL add_alu got %h exp 000C", o_alu); end
      checks++; if (o_pc !== 16'h0003) begin errors++; $display("FAIL add_pc got %h exp 0003", o_pc); end
      checks++; if (o_lat !== 3) begin errors++; $display("FAIL add_lat got %0d exp 3", o_lat); end
      exec_instr(16'h6100, 0, 16'h0, 0);
      checks++; if (o_wdata !== 16'h000C) begin errors++; $display("FAIL add_r1 got %h exp 000C", o_wdata); end
      checks++; if (o_lat !== 4) begin errors++; $display("FAIL sw_lat got %0d exp 4", o_lat); end
   endtask

   task automatic test_sub_logic();
      exec_instr(16'h7500, 0, 16'h0, 0);
      exec_instr(16'h7601, 0, 16'h0, 0);
      exec_instr(16'h2456, 0, 16'h0, 0);
      checks++; if (o_alu !== 16'hFFFF) begin errors++; $display("FAIL sub_wrap got %h exp FFFF", o_alu); end
      exec_instr(16'h5700, 1, 16'h00F0, 0);
      exec_instr(16'h5800, 0, 16'h0F0F, 0);
      exec_instr(16'h3978, 0, 16'h0, 0);
      checks++; if (o_alu !== 16'h0000) begin errors++; $display("FAIL and_res got %h exp 0000", o_alu); end
      exec_instr(16'h4A78, 0, 16'h0, 0);
      checks++; if (o_alu !== 16'h0FFF) begin errors++; $display("FAIL or_res got %h exp 0FFF", o_alu); end
   endtask

   task automatic test_load_wait();
      exec_instr(16'h7E04, 0, 16'h0, 0);
      exec_instr(16'h5DE0, 3, 16'hABCD, 0);
      checks++; if (o_addr !== 16'h0004) begin errors++; $display("FAIL lw_addr got %h exp 0004", o_addr); end
      checks++; if (o_rd !== 4) begin errors++; $display("FAIL lw_hold got %0d exp 4", o_rd); end
      checks++; if (o_lat !== 7) begin errors++; $display("FAIL lw_lat got %0d exp 7", o_lat); end
      exec_instr(16'h6D00, 0, 16'h0, 0);
      checks++; if (o_wdata !== 16'hABCD) begin errors++; $display("FAIL lw_r13 got %h exp ABCD", o_wdata); end
   endtask

   task automatic test_illegal();
      exec_instr(16'hF123, 0, 16'h0, 0);
      checks++; if (o_ill_exec !== 1'b1 || o_ill_cnt !== 1) begin errors++; $display("FAIL ill_pulse got %b/%0d exp 1/1", o_ill_exec, o_ill_cnt); end
      checks++; if (o_pc !== m_pc) begin errors++; $display("FAIL ill_pc got %h exp %h", o_pc, m_pc); end
      checks++; if (o_lat !== 3) begin errors++; $display("FAIL ill_lat got %0d exp 3", o_lat); end
`ifndef CPU_BRANCH_EN
      exec_instr(16'h8100, 0, 16'h0, 0);
      checks++; if (o_ill_cnt !== 1) begin errors++; $display("FAIL op8_ill got %0d exp 1", o_ill_cnt); end
`endif
      exec_instr(16'h6100, 0, 16'h0, 0);
      checks++; if (o_wdata !== 16'h000C) begin errors++; $display("FAIL ill_r1 got %h exp 000C", o_wdata); end
   endtask

   task automatic test_store_reset();
      exec_instr(16'h5F00, 0, 16'h1234, 0);
      instr = 16'h6F0F; instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL sw_req got w%b r%b exp w1 r0", mem_write, mem_read); end
      checks++; if (mem_addr !== 16'hFFFF) begin errors++; $display("FAIL sw_addr got %h exp FFFF", mem_addr); end
      checks++; if (mem_wdata !== 16'h1234) begin errors++; $display("FAIL sw_wdata got %h exp 1234", mem_wdata); end
      @(negedge clk);
      checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL sw_held got %b exp 1", mem_write); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mid_mem got %b exp 0", mem_write); end
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL rst_mid_pc got %h exp 0000", pc); end
      checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b exp 1", instr_ready); end
      exec_instr(16'h6F00, 0, 16'h0, 0);
      checks++; if (o_wdata !== 16'h0000) begin errors++; $display("FAIL rst_r15 got %h exp 0000", o_wdata); end
   endtask

`ifdef CPU_BRANCH_EN
   task automatic test_branch();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      repeat (5) exec_instr(16'h0000, 0, 16'h0, 0);
      exec_instr(16'h800E, 0, 16'h0, 0);
      checks++; if (o_pc !== 16'h0004) begin errors++; $display("FAIL beq_taken got %h exp 0004", o_pc); end
      checks++; if (o_ill_cnt !== 0) begin errors++; $display("FAIL beq_ill got %0d exp 0", o_ill_cnt); end
   endtask
`endif

   task automatic test_random();
      logic [15:0] ins;
      logic [3:0]  op;
      int          nw;
      for (int n = 0; n < 300; n++) begin
         op = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 7));
         ins = {op, 4'($urandom), 4'($urandom), 4'($urandom)};
         nw = $urandom_range(0, 3);
         exec_instr(ins, nw, 16'($urandom), $urandom_range(0, 2));
         checks++; if (o_to) begin errors++; $display("FAIL rand[%0d] timeout ins %h lat %0d exp %0d", n, ins, o_lat, exp_lat); end
         checks++; if (o_lat !== exp_lat) begin errors++; $display("FAIL rand[%0d] lat ins %h got %0d exp %0d", n, ins, o_lat, exp_lat); end
         checks++; if (o_pc !== m_pc) begin errors++; $display("FAIL rand[%0d] pc ins %h got %h exp %h", n, ins, o_pc, m_pc); end
         checks++; if (o_alu !== m_alu) begin errors++; $display("FAIL rand[%0d] alu ins %h got %h exp %h", n, ins, o_alu, m_alu); end
         checks++; if (o_ill_exec !== exp_ill || o_ill_cnt !== (exp_ill ? 1 : 0)) begin errors++; $display("FAIL rand[%0d] ill ins %h got %b/%0d exp %b", n, ins, o_ill_exec, o_ill_cnt, exp_ill); end
         if (exp_kind == 1) begin
            checks++; if (o_addr !== exp_addr || o_rd !== nw + 1 || o_wr !== 0) begin errors++; $display("FAIL rand[%0d] lw ins %h addr %h/%h rd %0d/%0d wr %0d", n, ins, o_addr, exp_addr, o_rd, nw + 1, o_wr); end
         end else if (exp_kind == 2) begin
            checks++; if (o_addr !== exp_addr || o_wdata !== exp_wdata || o_wr !== nw + 1 || o_rd !== 0) begin errors++; $display("FAIL rand[%0d] sw ins %h addr %h/%h data %h/%h wr %0d/%0d", n, ins, o_addr, exp_addr, o_wdata, exp_wdata, o_wr, nw + 1); end
         end else begin
            checks++; if (o_rd !== 0 || o_wr !== 0) begin errors++; $display("FAIL rand[%0d] nomem ins %h rd %0d wr %0d exp 0 0", n, ins, o_rd, o_wr); end
         end
      end
   endtask

   initial begin
      instr = 16'h0; instr_valid = 1'b0; mem_ready = 1'b0; mem_data = 16'h0;
      model_reset();
      test_reset();
      test_alu();
      test_sub_logic();
      test_load_wait();
      test_illegal();
      test_store_reset();
`ifdef CPU_BRANCH_EN
      test_branch();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
